univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_frame_counter.sv | 39 +++
 rtl/univ_shift_reg.sv | 80 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: the operating-mode
// encoding applied on the 2-bit mode input.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : shift_pkg

// File: rtl/shift_frame_counter.sv
// Counts executed shifts and emits a one-cycle frame_done pulse on the
// shift that completes a frame of WIDTH shifts.
module shift_frame_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    input  logic restart,
    output logic frame_done
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (clr || restart) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (step) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
                cnt        <= '0;
                frame_done <= 1'b1;
            end else begin
                cnt        <= cnt + CNT_W'(1);
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule : shift_frame_counter

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right with serial in/out,
// parallel load, and a frame-complete pulse every WIDTH shifts.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             frame_done
);

    mode_e op;
    logic  shift_step;
    logic  load_restart;

    assign op = mode_e'(mode);

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    always_comb begin
        shift_step   = 1'b0;
        load_restart = 1'b0;
        if (!clr && en) begin
            case (op)
                MODE_SHL, MODE_SHR: shift_step   = 1'b1;
                MODE_LOAD:          load_restart = 1'b1;
                default:            ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= '0;
            sout_l <= 1'b0;
            sout_r <= 1'b0;
        end else if (clr) begin
            q      <= '0;
            sout_l <= 1'b0;
            sout_r <= 1'b0;
        end else if (en) begin
            case (op)
                MODE_SHL: begin
                    q      <= {q[WIDTH-2:0], sin_l};
                    sout_l <= q[WIDTH-1];
                end
                MODE_SHR: begin
                    q      <= {sin_r, q[WIDTH-1:1]};
                    sout_r <= q[0];
                end
                MODE_LOAD: q <= pin;
                default:   ;
            endcase
        end
    end

    shift_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .step       (shift_step),
        .restart    (load_restart),
        .frame_done (frame_done)
    );

endmodule : univ_shift_reg
